// File: rtl/alu_defs.sv
// Definitions shared by the ALU-side blocks: FSM encodings and the
// width helper for slice counters.
package alu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A counter over `words` slices needs at least one bit even when words == 1.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle between the ALU operand registers
// and the wide-add sequencer; W is the full operand width.
interface wide_add_sequencer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] augend;
    logic [W-1:0] addend;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   final_sum;
    logic         busy;

    modport master (
        output in_valid, augend, addend, out_ready,
        input  in_ready, out_valid, final_sum, busy
    );

    modport slave (
        input  in_valid, augend, addend, out_ready,
        output in_ready, out_valid, final_sum, busy
    );
endinterface

// File: rtl/Adder.sv
// Narrow unsigned adder shared by the ALU; the carry-out is bit n of s.
module Adder #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n:0]   s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two W-bit operands one n-bit slice per cycle through a single shared
// Adder, chaining the carry between slices; result returned over valid/ready.
module wide_add_sequencer
    import alu_defs::*;
#(
    parameter int n     = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wide_add_sequencer_if.slave bus
);
    localparam int W    = n * WORDS;
    localparam int IDXW = idx_width(WORDS);

    state_t          state_reg;
    state_t          state_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            c_reg;
    logic [IDXW-1:0] idx_reg;
    logic [W:0]      sum_reg;
    logic [W-1:0]    res_next;
    logic [n:0]      s;
    logic [n:0]      t;
    logic            last_slice;

    Adder #(.n(n)) u_adder (
        .a (a_reg[n-1:0]),
        .b (b_reg[n-1:0]),
        .s (s)
    );

    // s + c peaks at 2^(n+1)-1, so n+1 bits never overflow.
    assign t          = s + {{n{1'b0}}, c_reg};
    assign last_slice = (idx_reg == IDXW'(WORDS - 1));

    // Earlier slices are kept top-aligned; the newest slice enters at the top
    // and, on the last slice, the oldest one lands in bits [n-1:0].
    generate
        if (WORDS == 1) begin : g_single
            assign res_next = t[n-1:0];
        end else begin : g_multi
            logic [W-n-1:0] acc_reg;

            assign res_next = {t[n-1:0], acc_reg};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (state_reg == RUN) begin
                    acc_reg <= res_next[W-1:n];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= 1'b0;
            idx_reg <= '0;
            sum_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.augend;
                        b_reg   <= bus.addend;
                        c_reg   <= 1'b0;
                        idx_reg <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> n;
                    b_reg   <= b_reg >> n;
                    c_reg   <= t[n];
                    idx_reg <= idx_reg + IDXW'(1);
                    if (last_slice) begin
                        sum_reg <= {t[n], res_next};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.final_sum = sum_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with n=4, WORDS=4: vector table plus
// hand-written reset and backpressure sequences.
module tb_wide_add_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wide_add_sequencer_if #(.W(16)) bus ();

    wide_add_sequencer #(.n(4), .WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    vec_t vecs [7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.augend   = a;
        bus.addend   = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_result(input logic [15:0] a, input logic [15:0] b, input logic [16:0] req);
        int cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", 32'(cycles), 32'd4);
        check("final_sum", 32'(bus.final_sum), 32'(req));
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        $display("op %04h + %04h -> %05h (required %05h) after %0d cycles",
                 a, b, bus.final_sum, req, cycles);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_release", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bit seen;

        vecs[0] = '{16'h1234, 16'h4321, 17'h05555};
        vecs[1] = '{16'hFFFF, 16'h0001, 17'h10000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[3] = '{16'h0000, 16'h0000, 17'h00000};
        vecs[4] = '{16'h8000, 16'h8000, 17'h10000};
        vecs[5] = '{16'h0F0F, 16'h00F1, 17'h01000};
        vecs[6] = '{16'hABCD, 16'h1234, 17'h0BE01};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.augend    = '0;
        bus.addend    = '0;

        // Power-on reset
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_final_sum", 32'(bus.final_sum), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_result(vecs[i].a, vecs[i].b, vecs[i].sum);
            release_result();
        end

        // Asynchronous reset in the middle of a cycle while in DONE
        start_op(16'h1234, 16'h4321);
        wait_result(16'h1234, 16'h4321, 17'h05555);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_final_sum", 32'(bus.final_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Backpressure: result held, new operands ignored
        start_op(16'h00F0, 16'h0F10);
        wait_result(16'h00F0, 16'h0F10, 17'h01000);
        bus.augend   = 16'h1111;
        bus.addend   = 16'h2222;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_final_sum", 32'(bus.final_sum), 32'h01000);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_result();
        start_op(16'h1111, 16'h2222);
        wait_result(16'h1111, 16'h2222, 17'h03333);
        release_result();

        // Reset after two slices of a running addition
        start_op(16'hAAAA, 16'h5555);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrun_no_out_valid", 32'(seen), 32'd0);
        start_op(16'h8000, 16'h8000);
        wait_result(16'h8000, 16'h8000, 17'h10000);
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide-operand adder controller. Accepts a pair of W-bit operands (W = n × WORDS) over a valid/ready handshake and adds them one n-bit slice per cycle, LSB slice first. All slices go through a single instance of the team's n-bit `Adder`, with the carry chained between slices. Returns the (W+1)-bit sum over a second valid/ready handshake. Sits between the ALU operand registers and the result bus, so wide additions reuse the existing narrow adder.

## Interface
Parameters:
- `n`, default 4: slice width; width of the shared `Adder` instance (n ≥ 1).
- `WORDS`, default 4: number of slices per operand (WORDS ≥ 1). W = n × WORDS.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block accepts operands.
- `augend`  in  W  first operand; sampled only on accept.
- `addend`  in  W  second operand; sampled only on accept.
- `out_valid`  out  1  `final_sum` holds a completed result.
- `out_ready`  in  1  consumer takes the result.
- `final_sum`  out  W+1  sum; bit W is the carry-out.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`: capture `augend` and `addend` into shift registers, clear carry register `c`, clear slice counter `idx`, go to RUN.
- RUN, per cycle:
  - Slice i is the low n bits of the operand shift registers.
  - `Adder` forms the (n+1)-bit value s = A_i + B_i.
  - t = s + c, computed in n+1 bits. This cannot overflow: the maximum is 2^(n+1) − 1.
  - t[n-1:0] shifts into the result register from the top. t[n] is the next `c`.
  - Operand registers shift right by n. `idx` increments.
  - When `idx` = WORDS−1 on this edge: load `final_sum` = {t[n], result}, go to DONE.
- DONE:
  - `out_valid` = 1. `final_sum` is held stable.
  - On `out_valid` && `out_ready`: go to IDLE.
- No overlap: `in_ready` = 0 in RUN and DONE. `in_valid` in those states is ignored and not queued.
- Arithmetic is unsigned and modulo-free. `final_sum` = `augend` + `addend` exactly, in W+1 bits.
- `final_sum` is meaningful only while `out_valid` = 1. It retains its last value otherwise.
- Reset, at any time including mid-RUN or in DONE:
  - State → IDLE; `out_valid`, `busy`, `c`, `idx`, `final_sum` and the internal registers → 0.
  - The partial result is discarded.
  - Reset values: `in_ready` = 1 (combinational from IDLE), `out_valid` = 0, `busy` = 0, `final_sum` = 0.

## Timing
- Accept on edge T0. Slices 0..WORDS−1 are processed on edges T0+1..T0+WORDS.
- `out_valid` rises after edge T0+WORDS, i.e. latency is WORDS cycles from accept.
- WORDS = 1 gives one RUN cycle.
- DONE lasts ≥ 1 cycle. The earliest return to IDLE is the edge after `out_valid` rises with `out_ready` high.
- The next accept is possible on the following edge. Minimum throughput is one operation per WORDS+2 cycles.
- `in_ready` and `busy` are decoded from registered state only; there is no combinational path from `in_valid`. `out_valid` is also from registered state only; there is no combinational path from `out_ready`.
- `idx` width is max(1, clog2(WORDS)).

## Structure
- Shared package/header (`alu_defs`):
  - FSM state encodings: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Derived-width helper for the `idx` counter.
- One sub-module: the existing `Adder` (parameter `n`), instantiated exactly once.
- The carry-in increment, shift registers and FSM stay in this block.

## Test plan
All with n = 4, WORDS = 4 (W = 16).
- Reset: assert `rst_n` = 0 asynchronously mid-cycle → immediately `out_valid` = 0, `busy` = 0, `final_sum` = 0; after release, `in_ready` = 1.
- Basic: accept 0x1234 + 0x4321 → `out_valid` exactly 4 cycles later, `final_sum` = 0x05555.
- Full carry ripple across slices: 0xFFFF + 0x0001 → `final_sum` = 0x10000.
- Maximum: 0xFFFF + 0xFFFF → `final_sum` = 0x1FFFE.
- Backpressure: after completing 0x00F0 + 0x0F10, hold `out_ready` = 0 for 10 cycles while driving `in_valid` = 1 with other data. Required during the stall:
  - `out_valid` stays 1, `final_sum` stays 0x01000, `in_ready` = 0.
  - The new operands are not taken.
  - After `out_ready`, return to IDLE; the next accept proceeds normally.
- Reset mid-RUN: pulse `rst_n` low after 2 slices of 0xAAAA + 0x5555 → IDLE, `out_valid` never asserts. A subsequent 0x8000 + 0x8000 gives 0x10000.
